// File: rtl/tile_pixel_compositor_if.sv
// Pixel coordinate stream into the compositor and composited RGB stream out of it.
interface tile_pixel_compositor_if;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       pix_valid;
   logic [3:0] out_r;
   logic [3:0] out_g;
   logic [3:0] out_b;
   logic       out_valid;

   modport master (output pix_x, pix_y, pix_valid, input out_r, out_g, out_b, out_valid);
   modport slave  (input pix_x, pix_y, pix_valid, output out_r, out_g, out_b, out_valid);
endinterface

// File: rtl/tile_pixel_compositor.sv
// Three-stage pixel compositor: maze tile lookup, sprite overlay and the
// two-frame sprite animation counter.
module tile_pixel_compositor #(
   parameter int TILE        = 16,
   parameter int MAP_W       = 28,
   parameter int MAP_H       = 31,
   parameter int ANIM_FRAMES = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   tile_pixel_compositor_if.slave   pix,
   input  logic                     frame_start,
   output logic [4:0]               map_col,
   output logic [4:0]               map_row,
   input  logic [1:0]               map_tile,
   input  logic [9:0]               player_x,
   input  logic [9:0]               player_y,
   input  logic [9:0]               ghost_x,
   input  logic [9:0]               ghost_y,
   input  logic [1:0]               ghost_dir,
   input  logic [TILE*TILE*4-1:0]   background_r,
   input  logic [TILE*TILE*4-1:0]   background_g,
   input  logic [TILE*TILE*4-1:0]   background_b,
   input  logic [TILE*TILE*4-1:0]   wall_r,
   input  logic [TILE*TILE*4-1:0]   wall_g,
   input  logic [TILE*TILE*4-1:0]   wall_b,
   input  logic [TILE*TILE-1:0]     player_mask_f1,
   input  logic [TILE*TILE-1:0]     player_mask_f2,
   input  logic [TILE*TILE-1:0]     ghost_mask_f1,
   input  logic [TILE*TILE-1:0]     ghost_mask_f2,
   input  logic [TILE*TILE-1:0]     dot_mask,
   input  logic [TILE*TILE-1:0]     big_dot_mask,
   input  logic [TILE*TILE-1:0]     ghost_sclera_mask_up,
   input  logic [TILE*TILE-1:0]     ghost_sclera_mask_down,
   input  logic [TILE*TILE-1:0]     ghost_sclera_mask_left,
   input  logic [TILE*TILE-1:0]     ghost_sclera_mask_right,
   input  logic [TILE*TILE-1:0]     ghost_eye_mask_up,
   input  logic [TILE*TILE-1:0]     ghost_eye_mask_down,
   input  logic [TILE*TILE-1:0]     ghost_eye_mask_left,
   input  logic [TILE*TILE-1:0]     ghost_eye_mask_right,
   output logic                     anim_frame
);
   localparam int TW = $clog2(TILE);
   localparam int PW = 2 * TW;

   logic [7:0]    anim_cnt;

   logic          s0_valid, s0_in_map, s0_anim;
   logic [9:0]    s0_x, s0_y, s0_px, s0_py, s0_gx, s0_gy;
   logic [1:0]    s0_dir;

   logic          s1_valid, s1_in_map, s1_anim, s1_phit, s1_ghit;
   logic [1:0]    s1_tile, s1_dir;
   logic [PW-1:0] s1_toff, s1_poff, s1_goff;

   logic          eye_bit, sclera_bit, body_bit, player_bit;
   logic [11:0]   rgb_nxt;

   // 11-bit compare so a sprite near the right/bottom edge never wraps.
   function automatic logic in_box(input logic [9:0] p, input logic [9:0] s);
      return ({1'b0, p} >= {1'b0, s}) && ({1'b0, p} < ({1'b0, s} + 11'(TILE)));
   endfunction

   function automatic logic [PW-1:0] sprite_off(input logic [9:0] x, input logic [9:0] y,
                                                input logic [9:0] sx, input logic [9:0] sy);
      logic [TW-1:0] dx, dy;
      dx = TW'(x - sx);
      dy = TW'(y - sy);
      return {dy, dx};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         anim_cnt   <= '0;
         anim_frame <= 1'b0;
      end else if (frame_start) begin
         if (anim_cnt == 8'(ANIM_FRAMES - 1)) begin
            anim_cnt   <= '0;
            anim_frame <= ~anim_frame;
         end else begin
            anim_cnt <= anim_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid  <= 1'b0;
         s0_in_map <= 1'b0;
         s0_anim   <= 1'b0;
         s0_x      <= '0;
         s0_y      <= '0;
         s0_px     <= '0;
         s0_py     <= '0;
         s0_gx     <= '0;
         s0_gy     <= '0;
         s0_dir    <= '0;
         map_col   <= '0;
         map_row   <= '0;
      end else begin
         s0_valid  <= pix.pix_valid;
         s0_in_map <= ({1'b0, pix.pix_x} < 11'(MAP_W * TILE)) &&
                      ({1'b0, pix.pix_y} < 11'(MAP_H * TILE));
         s0_anim   <= anim_frame;
         s0_x      <= pix.pix_x;
         s0_y      <= pix.pix_y;
         s0_px     <= player_x;
         s0_py     <= player_y;
         s0_gx     <= ghost_x;
         s0_gy     <= ghost_y;
         s0_dir    <= ghost_dir;
         map_col   <= 5'(pix.pix_x >> TW);
         map_row   <= 5'(pix.pix_y >> TW);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_in_map <= 1'b0;
         s1_anim   <= 1'b0;
         s1_phit   <= 1'b0;
         s1_ghit   <= 1'b0;
         s1_tile   <= '0;
         s1_dir    <= '0;
         s1_toff   <= '0;
         s1_poff   <= '0;
         s1_goff   <= '0;
      end else begin
         s1_valid  <= s0_valid;
         s1_in_map <= s0_in_map;
         s1_anim   <= s0_anim;
         s1_phit   <= in_box(s0_x, s0_px) && in_box(s0_y, s0_py);
         s1_ghit   <= in_box(s0_x, s0_gx) && in_box(s0_y, s0_gy);
         s1_tile   <= map_tile;
         s1_dir    <= s0_dir;
         s1_toff   <= {s0_y[TW-1:0], s0_x[TW-1:0]};
         s1_poff   <= sprite_off(s0_x, s0_y, s0_px, s0_py);
         s1_goff   <= sprite_off(s0_x, s0_y, s0_gx, s0_gy);
      end
   end

   always_comb begin
      eye_bit    = 1'b0;
      sclera_bit = 1'b0;
      case (s1_dir)
         2'd0: begin eye_bit = ghost_eye_mask_up[s1_goff];    sclera_bit = ghost_sclera_mask_up[s1_goff];    end
         2'd1: begin eye_bit = ghost_eye_mask_down[s1_goff];  sclera_bit = ghost_sclera_mask_down[s1_goff];  end
         2'd2: begin eye_bit = ghost_eye_mask_left[s1_goff];  sclera_bit = ghost_sclera_mask_left[s1_goff];  end
         default: begin eye_bit = ghost_eye_mask_right[s1_goff]; sclera_bit = ghost_sclera_mask_right[s1_goff]; end
      endcase
      body_bit   = s1_anim ? ghost_mask_f2[s1_goff]  : ghost_mask_f1[s1_goff];
      player_bit = s1_anim ? player_mask_f2[s1_poff] : player_mask_f1[s1_poff];

      rgb_nxt = 12'h000;
      if (!s1_valid || !s1_in_map)
         rgb_nxt = 12'h000;
      else if (s1_ghit && eye_bit)
         rgb_nxt = 12'h00f;
      else if (s1_ghit && sclera_bit)
         rgb_nxt = 12'hfff;
      else if (s1_ghit && body_bit)
         rgb_nxt = 12'hf00;
      else if (s1_phit && player_bit)
         rgb_nxt = 12'hff0;
      else if ((s1_tile == 2'd2 && dot_mask[s1_toff]) || (s1_tile == 2'd3 && big_dot_mask[s1_toff]))
         rgb_nxt = 12'hfb9;
      else if (s1_tile == 2'd1)
         rgb_nxt = {wall_r[{s1_toff, 2'b00} +: 4], wall_g[{s1_toff, 2'b00} +: 4], wall_b[{s1_toff, 2'b00} +: 4]};
      else
         rgb_nxt = {background_r[{s1_toff, 2'b00} +: 4], background_g[{s1_toff, 2'b00} +: 4],
                    background_b[{s1_toff, 2'b00} +: 4]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix.out_valid <= 1'b0;
         pix.out_r     <= '0;
         pix.out_g     <= '0;
         pix.out_b     <= '0;
      end else begin
         pix.out_valid <= s1_valid;
         pix.out_r     <= rgb_nxt[11:8];
         pix.out_g     <= rgb_nxt[7:4];
         pix.out_b     <= rgb_nxt[3:0];
      end
   end
endmodule

// File: tb/tb_tile_pixel_compositor.sv
// Scoreboard bench: stimulus pushes the expected pixel for the cycle it must
// appear on; a negedge monitor pops and compares.
module tb_tile_pixel_compositor;
   localparam int TILE = 16;
   localparam int NB   = TILE * TILE;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic frame_start = 1'b0;
   logic [4:0] map_col, map_row;
   logic [1:0] map_tile;
   logic [9:0] player_x, player_y, ghost_x, ghost_y;
   logic [1:0] ghost_dir;
   logic [NB*4-1:0] background_r, background_g, background_b, wall_r, wall_g, wall_b;
   logic [NB-1:0] player_mask_f1, player_mask_f2, ghost_mask_f1, ghost_mask_f2, dot_mask, big_dot_mask;
   logic [NB-1:0] sclera_up, sclera_down, sclera_left, sclera_right;
   logic [NB-1:0] eye_up, eye_down, eye_left, eye_right;
   logic anim_frame;
   logic [1:0] rom [32][32];

   tile_pixel_compositor_if pif();

   tile_pixel_compositor #(.TILE(16), .MAP_W(28), .MAP_H(31), .ANIM_FRAMES(8)) dut (
      .clk(clk), .rst(rst), .pix(pif), .frame_start(frame_start),
      .map_col(map_col), .map_row(map_row), .map_tile(map_tile),
      .player_x(player_x), .player_y(player_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
      .ghost_dir(ghost_dir),
      .background_r(background_r), .background_g(background_g), .background_b(background_b),
      .wall_r(wall_r), .wall_g(wall_g), .wall_b(wall_b),
      .player_mask_f1(player_mask_f1), .player_mask_f2(player_mask_f2),
      .ghost_mask_f1(ghost_mask_f1), .ghost_mask_f2(ghost_mask_f2),
      .dot_mask(dot_mask), .big_dot_mask(big_dot_mask),
      .ghost_sclera_mask_up(sclera_up), .ghost_sclera_mask_down(sclera_down),
      .ghost_sclera_mask_left(sclera_left), .ghost_sclera_mask_right(sclera_right),
      .ghost_eye_mask_up(eye_up), .ghost_eye_mask_down(eye_down),
      .ghost_eye_mask_left(eye_left), .ghost_eye_mask_right(eye_right),
      .anim_frame(anim_frame)
   );

   always #5 clk = ~clk;

   assign map_tile = rom[map_row][map_col];

   typedef struct {
      int          cyc;
      logic        v;
      logic [11:0] rgb;
      string       nm;
   } sb_t;

   sb_t sb[$];
   sb_t mon_ent;
   int  cyc = 0;
   int  passed = 0;
   int  total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         mon_ent = sb.pop_front();
         total++;
         if (pif.out_valid === mon_ent.v && {pif.out_r, pif.out_g, pif.out_b} === mon_ent.rgb)
            passed++;
         else
            $display("FAIL %s: cycle %0d got valid=%b rgb=%h, expected valid=%b rgb=%h", mon_ent.nm, cyc,
                     pif.out_valid, {pif.out_r, pif.out_g, pif.out_b}, mon_ent.v, mon_ent.rgb);
      end else if (pif.out_valid === 1'b1) begin
         total++;
         $display("FAIL unexpected_valid: cycle %0d got valid=1 rgb=%h, expected no output",
                  cyc, {pif.out_r, pif.out_g, pif.out_b});
      end
   end

   task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", nm, got, exp);
   endtask

   // One cycle of stimulus; the expected output lands three cycles later.
   task automatic step(input string nm, input int x, input int y, input logic v, input logic fs,
                       input logic r, input logic [11:0] e);
      sb_t ent;
      @(posedge clk);
      #1;
      pif.pix_x     = 10'(x);
      pif.pix_y     = 10'(y);
      pif.pix_valid = v;
      frame_start   = fs;
      rst           = r;
      if (r) begin
         for (int j = 0; j < sb.size(); j++) begin
            if (sb[j].cyc > cyc) begin
               ent     = sb[j];
               ent.v   = 1'b0;
               ent.rgb = 12'h000;
               sb[j]   = ent;
            end
         end
      end
      ent.cyc = cyc + 3;
      ent.v   = v && !r;
      ent.rgb = (v && !r) ? e : 12'h000;
      ent.nm  = nm;
      sb.push_back(ent);
   endtask

   task automatic idle();
      step("bubble", 0, 0, 1'b0, 1'b0, 1'b0, 12'h000);
   endtask

   initial begin
      int k;
      pif.pix_x = '0; pif.pix_y = '0; pif.pix_valid = 1'b0;
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            rom[r][c] = 2'd0;
      rom[0][0] = 2'd1; rom[2][3] = 2'd1; rom[0][27] = 2'd1;
      rom[5][1] = 2'd2; rom[5][2] = 2'd3;
      for (int p = 0; p < NB; p++) begin
         background_r[p*4 +: 4] = 4'(p);
         background_g[p*4 +: 4] = 4'(p >> 4);
         background_b[p*4 +: 4] = 4'h5;
         wall_r[p*4 +: 4] = 4'h0;
         wall_g[p*4 +: 4] = 4'(p >> 4);
         wall_b[p*4 +: 4] = 4'hf;
      end
      player_mask_f1 = '0; player_mask_f2 = '0; ghost_mask_f1 = '0; ghost_mask_f2 = '0;
      dot_mask = '0; big_dot_mask = '0;
      sclera_up = '0; sclera_down = '0; sclera_left = '0; sclera_right = '0;
      eye_up = '0; eye_down = '0; eye_left = '0; eye_right = '0;
      player_mask_f1[0] = 1'b1; player_mask_f1[3] = 1'b1; player_mask_f2[10] = 1'b1;
      ghost_mask_f1[0] = 1'b1; ghost_mask_f1[1] = 1'b1; ghost_mask_f1[2] = 1'b1;
      sclera_left[0] = 1'b1; sclera_left[1] = 1'b1; eye_left[0] = 1'b1; eye_up[1] = 1'b1;
      dot_mask[3] = 1'b1; big_dot_mask[5] = 1'b1;
      player_x = 10'd32; player_y = 10'd32; ghost_x = 10'd200; ghost_y = 10'd200; ghost_dir = 2'd2;

      repeat (3) step("reset", 0, 0, 1'b0, 1'b0, 1'b1, 12'h000);
      chk("reset_out_valid", 12'(pif.out_valid), 12'h000);
      chk("reset_out_rgb", {pif.out_r, pif.out_g, pif.out_b}, 12'h000);
      chk("reset_map_col", 12'(map_col), 12'h000);
      chk("reset_map_row", 12'(map_row), 12'h000);
      chk("reset_anim_frame", 12'(anim_frame), 12'h000);

      step("wall_px0", 0, 0, 1'b1, 1'b0, 1'b0, 12'h00f);
      repeat (3) idle();

      step("player_hit", 32, 32, 1'b1, 1'b0, 1'b0, 12'hff0);
      step("player_left_edge", 31, 32, 1'b1, 1'b0, 1'b0, 12'hf05);
      step("player_right_edge", 48, 32, 1'b1, 1'b0, 1'b0, 12'h00f);
      step("player_mask_clear", 47, 47, 1'b1, 1'b0, 1'b0, 12'hff5);
      step("player_bottom_edge", 32, 48, 1'b1, 1'b0, 1'b0, 12'h005);

      player_x = 10'd64; player_y = 10'd64; ghost_x = 10'd64; ghost_y = 10'd64;
      step("ghost_eye", 64, 64, 1'b1, 1'b0, 1'b0, 12'h00f);
      step("ghost_sclera", 65, 64, 1'b1, 1'b0, 1'b0, 12'hfff);
      step("ghost_body", 66, 64, 1'b1, 1'b0, 1'b0, 12'hf00);
      step("player_under_ghost", 67, 64, 1'b1, 1'b0, 1'b0, 12'hff0);
      step("sprites_clear", 68, 64, 1'b1, 1'b0, 1'b0, 12'h405);

      step("dot", 19, 80, 1'b1, 1'b0, 1'b0, 12'hfb9);
      step("dot_mask_clear", 20, 80, 1'b1, 1'b0, 1'b0, 12'h405);
      step("big_dot_uses_big_mask", 35, 80, 1'b1, 1'b0, 1'b0, 12'h305);
      step("big_dot", 37, 80, 1'b1, 1'b0, 1'b0, 12'hfb9);

      step("off_map_x", 448, 0, 1'b1, 1'b0, 1'b0, 12'h000);
      step("last_col", 447, 0, 1'b1, 1'b0, 1'b0, 12'h00f);
      step("off_map_y", 0, 496, 1'b1, 1'b0, 1'b0, 12'h000);
      step("last_row", 0, 495, 1'b1, 1'b0, 1'b0, 12'h0f5);
      repeat (5) idle();
      step("after_bubbles", 31, 32, 1'b1, 1'b0, 1'b0, 12'hf05);

      player_x = 10'd100; player_y = 10'd100;
      for (int i = 1; i <= 16; i++) begin
         if (i == 8) begin
            step("pixel_with_toggle_pulse", 110, 100, 1'b1, 1'b1, 1'b0, 12'he45);
            step("f2_after_toggle", 110, 100, 1'b1, 1'b0, 1'b0, 12'hff0);
         end else begin
            step("pulse", 0, 0, 1'b0, 1'b1, 1'b0, 12'h000);
            idle();
         end
         chk($sformatf("anim_frame_pulse%0d", i), 12'(anim_frame), (i >= 8 && i < 16) ? 12'h001 : 12'h000);
      end
      step("f1_after_second_toggle", 110, 100, 1'b1, 1'b0, 1'b0, 12'he45);

      for (int i = 0; i < 10; i++)
         step($sformatf("burst%0d", i), i * 17, 16, 1'b1, 1'b0, (i == 5 || i == 6), {4'(i), 8'h05});
      repeat (4) idle();

      k = 0;
      while (sb.size() > 0 && k < 10) begin
         @(posedge clk);
         k++;
      end
      total++;
      if (sb.size() == 0) passed++;
      else $display("FAIL drain: %0d entries left, expected 0", sb.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
